instr_fetch_exec: RTL
=====================

Name: instr_fetch_exec

Overview:
- Reader/consumer end of the instruction register.
- On `start`, walks `read_pointer` over a programmed window of `count` entries from `base_ptr`.
- Each step captures `instruction_word`, executes it (opcode on operand_a/operand_b), and presents a result on a valid/ready output stream.
- Sits beside the instruction register on the same clock. The testbench interface drives it and checks its results.

Parameters:
- `RES_W`, 64, result width; must be ≥ 2× operand width.
- `CNT_W`, 6, width of `count` and `res_index`; supports the full 32-entry register.

Ports:
- `clk`  input  1  single clock, rising-edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  one-cycle request; sampled only in IDLE.
- `base_ptr`  input  address_t (5)  first entry to read.
- `count`  input  CNT_W  number of entries to process, 0..32.
- `instruction_word`  input  instruction_t  entry addressed by `read_pointer`; combinational from the register.
- `read_pointer`  output  address_t (5)  read address to the register.
- `out_ready`  input  1  sink accepts the result.
- `res_valid`  output  1  result valid.
- `res_opcode`  output  opcode_t  opcode of the result.
- `res_value`  output  RES_W  signed result.
- `res_index`  output  CNT_W  0-based position in the window.
- `res_div0`  output  1  divide/mod by zero on this result.
- `busy`  output  1  state ≠ IDLE.
- `done`  output  1  one-cycle pulse when the window completes.

Behaviour:
- Reset values: all outputs 0; `read_pointer` = 0; state = IDLE; `res_opcode` = ZERO.
- FSM: IDLE → FETCH → EXEC → OUT → (FETCH | FIN) → IDLE.
- IDLE:
  - `start` = 1 and `count` ≠ 0: latch `base_ptr` into `read_pointer`, latch `count`, clear index, go to FETCH.
  - `start` = 1 and `count` = 0: pulse `done` next cycle; stay IDLE.
- FETCH: `read_pointer` is stable. At the clock edge, register `instruction_word` into `instr_q`; go to EXEC.
- EXEC: compute the result from `instr_q`. At the edge, register `res_*`, set `res_valid` = 1, go to OUT.
- OUT: hold all `res_*` stable while `out_ready` = 0. On the edge where `res_valid` && `out_ready`:
  - Deassert `res_valid`.
  - Index +1.
  - `read_pointer` +1 modulo 32 (31 → 0 wraps).
  - If index+1 == `count`, go to FIN; otherwise go to FETCH.
- FIN: `done` = 1 for exactly one cycle; go to IDLE.
- Latency: `start` edge → `res_valid` high after 3 rising edges. Best-case throughput: 1 result per 3 cycles.
- `start` while busy: ignored, no effect.
- Arithmetic: operands are signed 32-bit, sign-extended to `RES_W`.
  - ZERO = 0; PASSA = a; PASSB = b.
  - ADD = a+b; SUB = a−b; MULT = a*b (full 64-bit signed).
  - DIV = a/b; MOD = a%b, both truncating toward zero.
  - b = 0 for DIV/MOD: `res_value` = 0, `res_div0` = 1. Otherwise `res_div0` = 0.
  - Illegal opcode encodings produce 0.
- Reset asserted mid-operation: immediate return to reset values. No `done`, no further results.
- Instruction-register contents changing during a window: the value sampled at the FETCH edge is used.

Optional Feature:
- Macro: `INSTR_FETCH_EXEC_STATS_EN`.
- Defined: adds outputs `stat_exec` (16-bit) and `stat_div0` (16-bit).
  - `stat_exec` increments on each accepted result; `stat_div0` increments on each accepted result with `res_div0` = 1.
  - Both saturate at 16'hFFFF, clear on reset, and do not clear on `start`.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- `instr_register_pkg` already supplies `opcode_t`, `operand_t`, `address_t`, `instruction_t`. Add to it:
  - `result_t` (signed `RES_W`).
  - `fe_state_t` enum {IDLE, FETCH, EXEC, OUT, FIN}.
- Sub-module `instr_alu`: purely combinational, `instruction_t` in; `result_t` and div0 flag out. Instantiated once in EXEC.
- `tb_ifc` gains the reader-side signals: `start`, `base_ptr`, `count`, `out_ready`, and the `res_*`, `busy`, `done` outputs.

Test Plan:
- Entries 0..2 = {ADD 5,7}, {SUB 3,10}, {MULT −4,6}; `base_ptr`=0, `count`=3, `out_ready`=1 → results 12, −7, −24; `res_index` 0,1,2; `done` one cycle after the third accept; first `res_valid` 3 edges after `start`.
- Entry 4 = {DIV 9,0}, entry 5 = {MOD −7,2} → results 0 with `res_div0`=1, then −1 with `res_div0`=0.
- `base_ptr`=30, `count`=4 → `read_pointer` sequence 30, 31, 0, 1; four results; `done` pulse.
- `out_ready` held 0 for 5 cycles in OUT → `res_valid`/`res_value` stable for all 5 cycles; exactly one accept when `out_ready` rises.
- `count`=0 → `done` next cycle, `res_valid` never asserted, `busy` stays 0. Second `start` while busy → ignored.
- Drop `reset_n` during OUT of a 3-entry window → all outputs 0 asynchronously, no `done`. A new `start` after release runs correctly.

Source files
------------

// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its fetch/execute reader.
package instr_register_pkg;

    localparam int RESULT_W = 64;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic [4:0]         address_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    typedef logic signed [RESULT_W-1:0] result_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        OUT   = 3'd3,
        FIN   = 3'd4
    } fe_state_t;

    function automatic result_t sext(input operand_t x);
        return {{(RESULT_W-32){x[31]}}, x};
    endfunction

endpackage

// File: rtl/instr_alu.sv
// Combinational executor: one instruction in, signed result and divide-by-zero flag out.
module instr_alu
    import instr_register_pkg::*;
(
    input  instruction_t instr,
    output result_t      result,
    output logic         div0
);

    result_t a_s;
    result_t b_s;

    assign a_s = sext(instr.op_a);
    assign b_s = sext(instr.op_b);

    // Operands are widened first so MULT is full precision and DIV cannot overflow
    always_comb begin
        result = '0;
        div0   = 1'b0;
        case (instr.opc)
            ZERO:  result = '0;
            PASSA: result = a_s;
            PASSB: result = b_s;
            ADD:   result = a_s + b_s;
            SUB:   result = a_s - b_s;
            MULT:  result = a_s * b_s;
            DIV: begin
                if (b_s == '0) begin
                    div0 = 1'b1;
                end else begin
                    result = a_s / b_s;
                end
            end
            MOD: begin
                if (b_s == '0) begin
                    div0 = 1'b1;
                end else begin
                    result = a_s % b_s;
                end
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/instr_fetch_exec.sv
// Reader side of the instruction register: fetch a window, execute, stream results.
// Optional statistics counters enabled by INSTR_FETCH_EXEC_STATS_EN.
module instr_fetch_exec
    import instr_register_pkg::*;
#(
    parameter int RES_W = 64,
    parameter int CNT_W = 6
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  address_t                base_ptr,
    input  logic [CNT_W-1:0]        count,
    input  instruction_t            instruction_word,
    output address_t                read_pointer,
    input  logic                    out_ready,
    output logic                    res_valid,
    output opcode_t                 res_opcode,
    output logic signed [RES_W-1:0] res_value,
    output logic [CNT_W-1:0]        res_index,
    output logic                    res_div0,
    output logic                    busy,
    output logic                    done
`ifdef INSTR_FETCH_EXEC_STATS_EN
    ,
    output logic [15:0]             stat_exec,
    output logic [15:0]             stat_div0
`endif
);

    fe_state_t               state_r;
    address_t                rp_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [CNT_W-1:0]        idx_r;
    logic [CNT_W-1:0]        idx_nxt_s;
    instruction_t            instr_q_r;
    logic                    res_valid_r;
    opcode_t                 res_opcode_r;
    logic signed [RES_W-1:0] res_value_r;
    logic [CNT_W-1:0]        res_index_r;
    logic                    res_div0_r;
    logic                    busy_r;
    logic                    done_r;
    result_t                 alu_res_s;
    logic                    alu_div0_s;

    instr_alu u_alu (
        .instr  (instr_q_r),
        .result (alu_res_s),
        .div0   (alu_div0_s)
    );

    assign idx_nxt_s = idx_r + CNT_W'(1);

    // Window sequencer; result registers only move in EXEC so they hold through OUT
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            rp_r         <= 5'd0;
            cnt_r        <= '0;
            idx_r        <= '0;
            instr_q_r    <= '0;
            res_valid_r  <= 1'b0;
            res_opcode_r <= ZERO;
            res_value_r  <= '0;
            res_index_r  <= '0;
            res_div0_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            rp_r    <= base_ptr;
                            cnt_r   <= count;
                            idx_r   <= '0;
                            state_r <= FETCH;
                            busy_r  <= 1'b1;
                        end else begin
                            done_r <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    instr_q_r <= instruction_word;
                    state_r   <= EXEC;
                end
                EXEC: begin
                    res_opcode_r <= instr_q_r.opc;
                    res_value_r  <= RES_W'(alu_res_s);
                    res_div0_r   <= alu_div0_s;
                    res_index_r  <= idx_r;
                    res_valid_r  <= 1'b1;
                    state_r      <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        res_valid_r <= 1'b0;
                        idx_r       <= idx_nxt_s;
                        rp_r        <= rp_r + 5'd1;
                        if (idx_nxt_s == cnt_r) begin
                            state_r <= FIN;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= FETCH;
                        end
                    end
                end
                FIN: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    busy_r      <= 1'b0;
                    res_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign read_pointer = rp_r;
    assign res_valid    = res_valid_r;
    assign res_opcode   = res_opcode_r;
    assign res_value    = res_value_r;
    assign res_index    = res_index_r;
    assign res_div0     = res_div0_r;
    assign busy         = busy_r;
    assign done         = done_r;

`ifdef INSTR_FETCH_EXEC_STATS_EN
    logic        accept_s;
    logic [15:0] stat_exec_r;
    logic [15:0] stat_div0_r;

    assign accept_s = (state_r == OUT) && res_valid_r && out_ready;

    // Saturating counters of accepted results; survive across windows
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_exec_r <= 16'd0;
            stat_div0_r <= 16'd0;
        end else if (accept_s) begin
            if (stat_exec_r != 16'hFFFF) begin
                stat_exec_r <= stat_exec_r + 16'd1;
            end
            if (res_div0_r && (stat_div0_r != 16'hFFFF)) begin
                stat_div0_r <= stat_div0_r + 16'd1;
            end
        end
    end

    assign stat_exec = stat_exec_r;
    assign stat_div0 = stat_div0_r;
`endif

endmodule
